// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ requesters,
// with a registered write stage and read-after-write hazard flags for the write in flight.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter bit          DROP_R0 = 1'b1,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  regwrite,
  output logic [AW-1:0]         write_reg,
  output logic [DW-1:0]         write_data,
  input  logic [AW-1:0]         read_reg_num1,
  input  logic [AW-1:0]         read_reg_num2,
  output logic                  raw_hazard1,
  output logic                  raw_hazard2,
  output logic [IDW-1:0]        grant_id
);

  logic [IDW-1:0] r_ptr;
  logic           r_regwrite;
  logic [AW-1:0]  r_write_reg;
  logic [DW-1:0]  r_write_data;
  logic [IDW-1:0] r_grant_id;

  logic [IDW:0]   w_pick;
  logic           w_grant;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_next_ptr;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_data;
  logic           w_drop;
  logic           w_r0_mask;

  // Returns {found, index} of the first valid requester at or after the pointer.
  function automatic logic [IDW:0] f_pick(input logic [NUM_REQ-1:0] v,
                                          input logic [IDW-1:0]     p);
    logic [IDW:0] res;
    int unsigned  c;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (int'(p) + k) % NUM_REQ;
      if (v[c]) res = {1'b1, IDW'(c)};
    end
    return res;
  endfunction

  always_comb begin
    w_pick     = f_pick(req_valid, r_ptr);
    w_grant    = w_pick[IDW] & ~hold & reset;
    w_idx      = w_pick[IDW-1:0];
    w_next_ptr = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    w_addr     = req_addr[w_idx*AW +: AW];
    w_data     = req_data[w_idx*DW +: DW];
    w_drop     = DROP_R0 && (w_addr == '0);
    req_ready  = w_grant ? (NUM_REQ'(1) << w_idx) : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr        <= '0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_grant_id   <= '0;
    end else begin
      r_regwrite <= w_grant & ~w_drop;
      if (w_grant) r_ptr <= w_next_ptr;
      // Dropped r0 writes are consumed but leave the visible write stage untouched.
      if (w_grant && !w_drop) begin
        r_write_reg  <= w_addr;
        r_write_data <= w_data;
        r_grant_id   <= w_idx;
      end
    end
  end

  assign w_r0_mask   = DROP_R0 && (r_write_reg == '0);
  assign regwrite    = r_regwrite;
  assign write_reg   = r_write_reg;
  assign write_data  = r_write_data;
  assign grant_id    = r_grant_id;
  assign raw_hazard1 = r_regwrite && (r_write_reg == read_reg_num1) && !w_r0_mask;
  assign raw_hazard2 = r_regwrite && (r_write_reg == read_reg_num2) && !w_r0_mask;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based reference model predicts
// each cycle's write-port state; a monitor compares it one cycle after issue.
module tb_regfile_write_arbiter;
  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              hold = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [AW-1:0]     rd1 = '0;
  logic [AW-1:0]     rd2 = '0;
  logic [NR-1:0]     req_ready, nd_ready;
  logic              regwrite, nd_regwrite;
  logic [AW-1:0]     write_reg, nd_write_reg;
  logic [DW-1:0]     write_data, nd_write_data;
  logic              raw1, raw2, nd_raw1, nd_raw2;
  logic [1:0]        grant_id, nd_grant_id;

  regfile_write_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .DROP_R0(1'b1)) u_dut (
    .clock(clock), .reset(reset), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .regwrite(regwrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg_num1(rd1), .read_reg_num2(rd2),
    .raw_hazard1(raw1), .raw_hazard2(raw2), .grant_id(grant_id)
  );

  regfile_write_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .DROP_R0(1'b0)) u_dut_nd (
    .clock(clock), .reset(reset), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(nd_ready), .regwrite(nd_regwrite),
    .write_reg(nd_write_reg), .write_data(nd_write_data), .read_reg_num1(rd1),
    .read_reg_num2(rd2), .raw_hazard1(nd_raw1), .raw_hazard2(nd_raw2),
    .grant_id(nd_grant_id)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [1:0]    gid;
  } exp_t;

  exp_t          q[$];
  exp_t          m_out;
  int            m_ptr;
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] s_addr[NR];
  logic [DW-1:0] s_data[NR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0;
    m_out = '0;
    q.delete();
  endtask

  // Drive one cycle of requests and predict the outcome from the arbitration rules.
  task automatic step(input logic [NR-1:0] v, input logic h,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    int            win;
    logic [NR-1:0] exp_rdy;
    exp_t          nx;
    @(negedge clock);
    req_valid = v;
    hold      = h;
    rd1       = r1;
    rd2       = r2;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = s_addr[i];
      req_data[i*DW +: DW] = s_data[i];
    end
    #1;
    win = -1;
    if (!h) begin
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (win < 0 && v[c]) win = c;
      end
    end
    exp_rdy = (win >= 0) ? (NR'(1) << win) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    nx    = m_out;
    nx.rw = 1'b0;
    if (win >= 0) begin
      m_ptr = (win + 1) % NR;
      if (s_addr[win] != 0) begin
        nx.rw  = 1'b1;
        nx.wr  = s_addr[win];
        nx.wd  = s_data[win];
        nx.gid = 2'(win);
      end
    end
    m_out = nx;
    q.push_back(nx);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset && q.size() > 0) begin
        e = q.pop_front();
        chk("regwrite", 64'(regwrite), 64'(e.rw));
        chk("write_reg", 64'(write_reg), 64'(e.wr));
        chk("write_data", 64'(write_data), 64'(e.wd));
        chk("grant_id", 64'(grant_id), 64'(e.gid));
        chk("raw_hazard1", 64'(raw1), 64'(e.rw && e.wr == rd1 && e.wr != 0));
        chk("raw_hazard2", 64'(raw2), 64'(e.rw && e.wr == rd2 && e.wr != 0));
      end
    end
  end

  initial begin
    int waited;
    m_reset();
    for (int i = 0; i < NR; i++) begin
      s_addr[i] = AW'(i + 4);
      s_data[i] = DW'(32'h100 + i);
    end

    // Reset held with every requester valid.
    req_valid = '1;
    repeat (2) @(negedge clock);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    req_valid = '0;
    reset     = 1'b1;

    // Round-robin with all four valid: grants 0,1,2,3,0,1,2,3.
    repeat (8) step(4'b1111, 1'b0, AW'(5), AW'(7));
    step(4'b0000, 1'b0, '0, '0);

    // Single writer: req2 writes 30 to r1, hazard on read port 1.
    s_addr[2] = AW'(1);
    s_data[2] = DW'(30);
    step(4'b0100, 1'b0, AW'(1), AW'(3));
    step(4'b0000, 1'b0, AW'(1), AW'(1));

    // r0 write from req1: dropped here, committed by the DROP_R0=0 instance.
    s_addr[1] = '0;
    s_data[1] = DW'(20);
    step(4'b0010, 1'b0, '0, '0);
    @(posedge clock);
    #1;
    chk("nd_regwrite", 64'(nd_regwrite), 64'd1);
    chk("nd_write_reg", 64'(nd_write_reg), 64'd0);
    chk("nd_write_data", 64'(nd_write_data), 64'd20);

    // Hold for three cycles with req0/req3 valid, then release.
    s_addr[0] = AW'(9);
    s_addr[3] = AW'(11);
    repeat (3) step(4'b1001, 1'b1, AW'(9), AW'(11));
    step(4'b1001, 1'b0, AW'(9), AW'(11));
    step(4'b1001, 1'b0, AW'(9), AW'(11));

    // Mid-op reset: the write accepted in this cycle must never commit.
    step(4'b0100, 1'b0, '0, '0);
    step(4'b1000, 1'b0, '0, '0);
    #2;
    reset = 1'b0;
    m_reset();
    @(posedge clock);
    #1;
    chk("midrst_regwrite", 64'(regwrite), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    chk("midrst_regwrite2", 64'(regwrite), 64'd0);
    req_valid = '0;
    reset     = 1'b1;
    step(4'b1111, 1'b0, '0, '0);

    // Randomized traffic, small address range to exercise r0 and hazards.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        s_addr[i] = AW'($urandom_range(0, 3));
        s_data[i] = DW'($urandom);
      end
      step(NR'($urandom), ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 3)),
           AW'($urandom_range(0, 3)));
    end
    step(4'b0000, 1'b0, '0, '0);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
